mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl_pkg.sv | 108 ++++++++++
 rtl/mc_ctrl_if.sv | 36 +++
 rtl/mc_decode.sv | 34 +++
 rtl/mc_ctrl.sv | 177 +++++++++++++++++
 tb/tb_mc_ctrl.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle controller: FSM state encodings,
// MIPS opcode/funct constants, datapath mux-select encodings and the
// one-hot instruction class record produced by the decoder.
package mc_ctrl_pkg;

  // FSM states; encodings 5-7 are unused and recover to FETCH.
  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXE    = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4
  } state_e;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct codes
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // Next-PC source
  localparam logic [2:0] NPC_PC4  = 3'b000;
  localparam logic [2:0] NPC_BEQ  = 3'b001;
  localparam logic [2:0] NPC_JAL  = 3'b010;
  localparam logic [2:0] NPC_JR   = 3'b011;
  localparam logic [2:0] NPC_J    = 3'b100;

  // Register-file write address select
  localparam logic [2:0] RD_RD    = 3'b000;
  localparam logic [2:0] RD_RT    = 3'b001;
  localparam logic [2:0] RD_RA    = 3'b010;

  // Register-file write data select
  localparam logic [2:0] M2R_ALU  = 3'b000;
  localparam logic [2:0] M2R_MEM  = 3'b001;
  localparam logic [2:0] M2R_PC   = 3'b010;

  // ALU B-operand select
  localparam logic [2:0] SRC_REG  = 3'b000;
  localparam logic [2:0] SRC_IMM  = 3'b001;

  // Immediate extender mode
  localparam logic [1:0] EXT_ZERO = 2'b00;
  localparam logic [1:0] EXT_SIGN = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;

  // ALU operation
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;

  // One-hot instruction class; exactly one flag is set for any Instr.
  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic j;
    logic jal;
    logic jr;
    logic bad;
  } insn_class_t;

  // ALU-side selects, driven in EXE and held through MEM.
  typedef struct packed {
    logic [2:0] alu_src;
    logic [1:0] ext_op;
    logic [1:0] alu_op;
  } exe_sel_t;

  // ALU-side selects for an instruction class; zero for classes without an
  // ALU phase (beq compares through the external Zero flag only).
  function automatic exe_sel_t exe_selects(insn_class_t c);
    exe_sel_t s;
    s = '0;
    if (c.ori) begin
      s.alu_src = SRC_IMM;
      s.ext_op  = EXT_ZERO;
      s.alu_op  = ALU_OR;
    end else if (c.lw || c.sw) begin
      s.alu_src = SRC_IMM;
      s.ext_op  = EXT_SIGN;
      s.alu_op  = ALU_ADD;
    end else if (c.lui) begin
      s.alu_src = SRC_IMM;
      s.ext_op  = EXT_LUI;
      s.alu_op  = ALU_ADD;
    end else if (c.subu) begin
      s.alu_src = SRC_REG;
      s.ext_op  = EXT_ZERO;
      s.alu_op  = ALU_SUB;
    end
    return s;
  endfunction

endpackage

// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath bundle: instruction/flag inputs to the controller
// and all enables, mux selects and debug/status outputs back to the datapath.
interface mc_ctrl_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        PCWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic        MemWrite;
  logic [2:0]  RegDst;
  logic [2:0]  MemToReg;
  logic [2:0]  ALUSrc;
  logic [2:0]  NPCop;
  logic [1:0]  Extop;
  logic [1:0]  ALUop;
  logic [2:0]  state;
  logic        retire;
  logic        illegal;
  logic [31:0] retired_cnt;

  // Controller side
  modport master (
    input  Instr, Zero,
    output PCWrite, IRWrite, RegWrite, MemWrite,
    output RegDst, MemToReg, ALUSrc, NPCop, Extop, ALUop,
    output state, retire, illegal, retired_cnt
  );

  // Datapath side
  modport slave (
    output Instr, Zero,
    input  PCWrite, IRWrite, RegWrite, MemWrite,
    input  RegDst, MemToReg, ALUSrc, NPCop, Extop, ALUop,
    input  state, retire, illegal, retired_cnt
  );
endinterface

// File: rtl/mc_decode.sv
// Combinational instruction classifier: maps opcode/funct onto one-hot
// class flags. Anything outside the supported set raises only 'bad'.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output insn_class_t cls
);

  // Opcode first, funct only for the R-type group.
  always_comb begin
    cls = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADDU: cls.addu = 1'b1;
          FN_SUBU: cls.subu = 1'b1;
          FN_JR:   cls.jr   = 1'b1;
          default: cls.bad  = 1'b1;
        endcase
      end
      OP_ORI:  cls.ori = 1'b1;
      OP_LUI:  cls.lui = 1'b1;
      OP_LW:   cls.lw  = 1'b1;
      OP_SW:   cls.sw  = 1'b1;
      OP_BEQ:  cls.beq = 1'b1;
      OP_J:    cls.j   = 1'b1;
      OP_JAL:  cls.jal = 1'b1;
      default: cls.bad = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS controller: FETCH/DECODE/EXE/MEM/WB state machine with
// Moore outputs (PCWrite in EXE also follows Zero for beq) and a counter of
// retired instructions. Instruction classification lives in mc_decode.
module mc_ctrl
  import mc_ctrl_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  mc_ctrl_if.master bus
);

  state_e      state_reg;
  state_e      state_next;
  logic [31:0] cnt_reg;
  insn_class_t cls;
  exe_sel_t    exe_sel;

  logic        pc_write;
  logic        ir_write;
  logic        reg_write;
  logic        mem_write;
  logic [2:0]  reg_dst;
  logic [2:0]  mem_to_reg;
  logic [2:0]  alu_src;
  logic [2:0]  npc_op;
  logic [1:0]  ext_op;
  logic [1:0]  alu_op;
  logic        retire;
  logic        illegal;

  mc_decode u_decode (
    .opcode (bus.Instr[31:26]),
    .funct  (bus.Instr[5:0]),
    .cls    (cls)
  );

  // Register/immediate fields are consumed by the datapath, not here.
  logic unused_instr_fields;
  assign unused_instr_fields = ^bus.Instr[25:6];

  assign exe_sel = exe_selects(cls);

  // State register and retire counter; reset abandons any in-flight instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_FETCH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (retire) begin
        cnt_reg <= cnt_reg + 32'd1;
      end
    end
  end

  // Next-state and output decode; every output defaults to 0 in each state.
  always_comb begin
    state_next = ST_FETCH;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    mem_write  = 1'b0;
    reg_dst    = RD_RD;
    mem_to_reg = M2R_ALU;
    alu_src    = SRC_REG;
    npc_op     = NPC_PC4;
    ext_op     = EXT_ZERO;
    alu_op     = ALU_ADD;
    retire     = 1'b0;
    illegal    = 1'b0;

    case (state_reg)
      ST_FETCH: begin
        ir_write   = 1'b1;
        pc_write   = 1'b1;
        npc_op     = NPC_PC4;
        state_next = ST_DECODE;
      end

      ST_DECODE: begin
        if (cls.j) begin
          pc_write = 1'b1;
          npc_op   = NPC_J;
        end else if (cls.jal) begin
          pc_write = 1'b1;
          npc_op   = NPC_JAL;
        end else if (cls.jr) begin
          pc_write = 1'b1;
          npc_op   = NPC_JR;
        end
        illegal = cls.bad;
        // Jumps and unsupported opcodes finish here.
        if (cls.j || cls.jr || cls.bad) begin
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (cls.jal) begin
          state_next = ST_WB;
        end else begin
          state_next = ST_EXE;
        end
      end

      ST_EXE: begin
        alu_src = exe_sel.alu_src;
        ext_op  = exe_sel.ext_op;
        alu_op  = exe_sel.alu_op;
        if (cls.beq) begin
          npc_op     = NPC_BEQ;
          pc_write   = bus.Zero;
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else if (cls.lw || cls.sw) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end

      ST_MEM: begin
        // Address path stays as set up in EXE while memory is accessed.
        alu_src   = exe_sel.alu_src;
        ext_op    = exe_sel.ext_op;
        alu_op    = exe_sel.alu_op;
        mem_write = cls.sw;
        if (cls.sw) begin
          retire     = 1'b1;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_WB;
        end
      end

      ST_WB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        if (cls.ori || cls.lui) begin
          reg_dst = RD_RT;
        end else if (cls.lw) begin
          reg_dst    = RD_RT;
          mem_to_reg = M2R_MEM;
        end else if (cls.jal) begin
          reg_dst    = RD_RA;
          mem_to_reg = M2R_PC;
        end
        state_next = ST_FETCH;
      end

      default: state_next = ST_FETCH;
    endcase

    // No writes or pulses escape while reset is held, whatever the state.
    if (reset) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      retire    = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign bus.PCWrite     = pc_write;
  assign bus.IRWrite     = ir_write;
  assign bus.RegWrite    = reg_write;
  assign bus.MemWrite    = mem_write;
  assign bus.RegDst      = reg_dst;
  assign bus.MemToReg    = mem_to_reg;
  assign bus.ALUSrc      = alu_src;
  assign bus.NPCop       = npc_op;
  assign bus.Extop       = ext_op;
  assign bus.ALUop       = alu_op;
  assign bus.state       = state_reg;
  assign bus.retire      = retire;
  assign bus.illegal     = illegal;
  assign bus.retired_cnt = cnt_reg;

endmodule

// File: tb/tb_mc_ctrl.sv
// Testbench for mc_ctrl: directed instruction scenarios followed by a random
// instruction stream (with occasional mid-instruction reset), each cycle
// compared against a table-driven model of the per-instruction behaviour.
module tb_mc_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  mc_ctrl_if bus();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int model_cnt = 0;

  typedef enum int {
    K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_JR, K_BAD
  } kind_e;

  typedef struct packed {
    logic       pcw;
    logic       irw;
    logic       regw;
    logic       memw;
    logic [2:0] regdst;
    logic [2:0] m2r;
    logic [2:0] alusrc;
    logic [2:0] npc;
    logic [1:0] ext;
    logic [1:0] aluop;
    logic       retire;
    logic       illegal;
  } outs_t;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Instruction kind from the MIPS encoding.
  function automatic kind_e classify(logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] fn;
    op = ins[31:26];
    fn = ins[5:0];
    case (op)
      6'h00: begin
        if (fn == 6'h21)      return K_ADDU;
        else if (fn == 6'h23) return K_SUBU;
        else if (fn == 6'h08) return K_JR;
        else                  return K_BAD;
      end
      6'h0D: return K_ORI;
      6'h0F: return K_LUI;
      6'h23: return K_LW;
      6'h2B: return K_SW;
      6'h04: return K_BEQ;
      6'h02: return K_J;
      6'h03: return K_JAL;
      default: return K_BAD;
    endcase
  endfunction

  // Visited states, one nibble per cycle starting at nibble 0.
  function automatic logic [19:0] path_seq(kind_e k);
    case (k)
      K_ADDU, K_SUBU, K_ORI, K_LUI: return 20'h04210;
      K_LW:  return 20'h43210;
      K_SW:  return 20'h03210;
      K_BEQ: return 20'h00210;
      K_JAL: return 20'h00410;
      default: return 20'h00010;
    endcase
  endfunction

  function automatic int path_len(kind_e k);
    case (k)
      K_ADDU, K_SUBU, K_ORI, K_LUI, K_SW: return 4;
      K_LW:  return 5;
      K_BEQ, K_JAL: return 3;
      default: return 2;
    endcase
  endfunction

  // Expected controller outputs for one cycle of an instruction.
  function automatic outs_t expect_outs(kind_e k, int st, logic z, bit last);
    outs_t e;
    e = '0;
    if (st == 0) begin
      e.pcw = 1'b1;
      e.irw = 1'b1;
    end
    if (st == 1) begin
      if (k == K_J)   begin e.pcw = 1'b1; e.npc = 3'b100; end
      if (k == K_JAL) begin e.pcw = 1'b1; e.npc = 3'b010; end
      if (k == K_JR)  begin e.pcw = 1'b1; e.npc = 3'b011; end
      if (k == K_BAD) e.illegal = 1'b1;
    end
    if (st == 2 || st == 3) begin
      case (k)
        K_ORI:      begin e.alusrc = 3'b001; e.ext = 2'b00; e.aluop = 2'b10; end
        K_LW, K_SW: begin e.alusrc = 3'b001; e.ext = 2'b01; e.aluop = 2'b00; end
        K_LUI:      begin e.alusrc = 3'b001; e.ext = 2'b10; e.aluop = 2'b00; end
        K_SUBU:     begin e.alusrc = 3'b000; e.ext = 2'b00; e.aluop = 2'b01; end
        default:    ;
      endcase
    end
    if (st == 2 && k == K_BEQ) begin
      e.npc = 3'b001;
      e.pcw = z;
    end
    if (st == 3) e.memw = (k == K_SW);
    if (st == 4) begin
      e.regw = 1'b1;
      case (k)
        K_ORI, K_LUI: e.regdst = 3'b001;
        K_LW:  begin e.regdst = 3'b001; e.m2r = 3'b001; end
        K_JAL: begin e.regdst = 3'b010; e.m2r = 3'b010; end
        default: ;
      endcase
    end
    e.retire = last;
    return e;
  endfunction

  function automatic outs_t sample_outs();
    outs_t o;
    o.pcw     = bus.PCWrite;
    o.irw     = bus.IRWrite;
    o.regw    = bus.RegWrite;
    o.memw    = bus.MemWrite;
    o.regdst  = bus.RegDst;
    o.m2r     = bus.MemToReg;
    o.alusrc  = bus.ALUSrc;
    o.npc     = bus.NPCop;
    o.ext     = bus.Extop;
    o.aluop   = bus.ALUop;
    o.retire  = bus.retire;
    o.illegal = bus.illegal;
    return o;
  endfunction

  // Random encoding of a given kind.
  function automatic logic [31:0] gen_insn(kind_e k);
    logic [31:0] r;
    r = $urandom;
    case (k)
      K_ADDU: return {6'h00, r[25:11], 5'h00, 6'h21};
      K_SUBU: return {6'h00, r[25:11], 5'h00, 6'h23};
      K_JR:   return {6'h00, r[25:21], 15'h0000, 6'h08};
      K_ORI:  return {6'h0D, r[25:0]};
      K_LUI:  return {6'h0F, r[25:0]};
      K_LW:   return {6'h23, r[25:0]};
      K_SW:   return {6'h2B, r[25:0]};
      K_BEQ:  return {6'h04, r[25:0]};
      K_J:    return {6'h02, r[25:0]};
      K_JAL:  return {6'h03, r[25:0]};
      default: begin
        for (int t = 0; t < 200; t++) begin
          if (classify(r) == K_BAD) return r;
          r = $urandom;
        end
        return 32'hFC000000;
      end
    endcase
  endfunction

  // Run one instruction starting in FETCH (#1 after an edge). Zero is either
  // fixed or re-randomised each cycle; abort_at >= 0 raises reset in that cycle.
  task automatic run_insn(input logic [31:0] ins, input logic zero_fixed,
                          input bit rand_zero, input int abort_at);
    kind_e       k;
    logic [19:0] seq;
    int          len;
    int          st;
    outs_t       e;
    outs_t       o;
    k   = classify(ins);
    seq = path_seq(k);
    len = path_len(k);
    bus.Instr = ins;
    for (int i = 0; i < len; i++) begin
      bus.Zero = rand_zero ? 1'($urandom_range(0, 1)) : zero_fixed;
      st = int'(seq[4*i +: 4]);
      if (i == abort_at) begin
        reset = 1'b1;
        @(negedge clk);
        chk("abort_state", 32'(bus.state), 32'(st));
        chk("abort_enables", {26'd0, bus.PCWrite, bus.IRWrite, bus.RegWrite,
                              bus.MemWrite, bus.retire, bus.illegal}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_cnt = 0;
        chk("abort_next_state", 32'(bus.state), 32'd0);
        chk("abort_cnt", bus.retired_cnt, 32'(model_cnt));
        $display("insn %08h kind %0d aborted in cycle %0d cnt %0d", ins, k, i, model_cnt);
        return;
      end
      e = expect_outs(k, st, bus.Zero, i == len - 1);
      @(negedge clk);
      o = sample_outs();
      chk($sformatf("state[%0d]", i), 32'(bus.state), 32'(st));
      chk($sformatf("outs[%0d]", i), 32'(o), 32'(e));
      @(posedge clk);
      #1;
      if (i == len - 1) model_cnt++;
    end
    chk("retired_cnt", bus.retired_cnt, 32'(model_cnt));
    chk("back_to_fetch", 32'(bus.state), 32'd0);
    $display("insn %08h kind %0d cycles %0d cnt %0d", ins, k, len, model_cnt);
  endtask

  initial begin
    kind_e k;
    logic [31:0] ins;
    int ab;
    bus.Instr = 32'h0;
    bus.Zero  = 1'b0;
    reset     = 1'b1;

    // Reset state; enables must stay low while reset is held.
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_state", 32'(bus.state), 32'd0);
    chk("reset_cnt", bus.retired_cnt, 32'd0);
    chk("reset_enables", {26'd0, bus.PCWrite, bus.IRWrite, bus.RegWrite,
                          bus.MemWrite, bus.retire, bus.illegal}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Directed scenarios
    run_insn(32'h00221821, 1'b0, 1'b0, -1);  // addu
    run_insn(32'h8C220004, 1'b0, 1'b0, -1);  // lw
    run_insn(32'h10220003, 1'b1, 1'b0, -1);  // beq taken
    run_insn(32'h10220003, 1'b0, 1'b0, -1);  // beq not taken
    run_insn(32'h0C000010, 1'b0, 1'b0, -1);  // jal
    run_insn(32'hAC220008, 1'b0, 1'b0, 3);   // sw, reset in MEM
    run_insn(32'hFC000000, 1'b0, 1'b0, -1);  // unsupported
    run_insn(32'h08000004, 1'b0, 1'b0, -1);  // j
    run_insn(32'h03E00008, 1'b0, 1'b0, -1);  // jr
    run_insn(32'h3422FFFF, 1'b0, 1'b0, -1);  // ori
    run_insn(32'h3C021234, 1'b0, 1'b0, -1);  // lui
    run_insn(32'h00221823, 1'b0, 1'b0, -1);  // subu
    run_insn(32'hAC220008, 1'b0, 1'b0, -1);  // sw complete

    // Random instruction stream
    for (int n = 0; n < 250; n++) begin
      k   = kind_e'($urandom_range(0, 10));
      ins = gen_insn(k);
      ab  = ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, path_len(classify(ins)) - 1)) : -1;
      run_insn(ins, 1'b0, 1'b1, ab);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
